mem_arbiter: RTL and testbench

Two-requester arbiter that shares one `tinymemif` memory port between the core's instruction-fetch path and its load/store path. Each cycle it grants at most one read and at most one write. Read data comes back one cycle later through a registered response. Data accesses have priority, and a bounded starvation counter protects instruction fetch. The block sits between the pipeline's fetch/memory stages and the `tinymemif.slave` memory model.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Access-size encoding and the tinymemif memory port.
// The arbiter drives the port as master; the memory model uses the slave side.
package tinymem_pkg;
    localparam logic [1:0] MEM_ACCESS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_ACCESS_SIZE_WORD = 2'd2;
endpackage

interface tinymemif;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic [31:0] rd_data;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic        busy;

    modport master (
        output rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
        output rd_data, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one tinymemif port between instruction fetch and load/store.
// Data wins the read port, but fetch is forced through after STARVE_LIMIT denials.
module mem_arbiter
    import tinymem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [1:0]  d_size_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    tinymemif.master    memif
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             pend_q, pend_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             if_gnt, d_gnt, d_rd_gnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == LIMIT_C) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        starve_cnt_d = starve_cnt_q;
        if (!(memif.busy || reset_i)) begin
            if (d_req_i && d_we_i) begin
                d_gnt        = 1'b1;
                if_gnt       = if_req_i;
                starve_cnt_d = '0;
            end else if (d_req_i) begin
                if (if_req_i && starve_cnt_q == LIMIT_C) begin
                    if_gnt       = 1'b1;
                    starve_cnt_d = '0;
                end else begin
                    d_gnt        = 1'b1;
                    starve_cnt_d = if_req_i ? sat_inc(starve_cnt_q) : '0;
                end
            end else if (if_req_i) begin
                if_gnt       = 1'b1;
                starve_cnt_d = '0;
            end
        end
    end

    assign d_rd_gnt = d_gnt & ~d_we_i;

    // Only one read can win the port per cycle, so a single owner flag suffices.
    always_comb begin
        pend_d     = if_gnt | d_rd_gnt;
        owner_d    = owner_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (if_gnt) begin
            owner_d    = OWNER_IF;
            if_rdata_d = memif.rd_data;
        end else if (d_rd_gnt) begin
            owner_d   = OWNER_D;
            d_rdata_d = memif.rd_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
            pend_q       <= 1'b0;
            owner_q      <= OWNER_IF;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pend_q       <= pend_d;
            owner_q      <= owner_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Gating with reset squashes a response scheduled just before reset rises.
    assign if_rvalid_o = pend_q & (owner_q == OWNER_IF) & ~reset_i;
    assign d_rvalid_o  = pend_q & (owner_q == OWNER_D) & ~reset_i;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_gnt_o    = if_gnt;
    assign d_gnt_o     = d_gnt;

    assign memif.rd_addr   = d_rd_gnt ? d_addr_i : if_addr_i;
    assign memif.rd_size   = d_rd_gnt ? d_size_i : MEM_ACCESS_SIZE_WORD;
    assign memif.wr_addr   = d_addr_i;
    assign memif.wr_size   = d_size_i;
    assign memif.wr_data   = d_wdata_i;
    assign memif.wr_enable = d_gnt & d_we_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a randomized
// run against a cycle-level reference of the arbitration rules.
module tb_mem_arbiter;
    import tinymem_pkg::*;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        if_req, d_req, d_we, busy;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [31:0] if_rdata, d_rdata;

    logic        poke_en;
    logic [31:0] poke_addr, poke_data;
    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;

    tinymemif mif ();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_size_i   (d_size),
        .d_wdata_i  (d_wdata),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
        .memif      (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] s);
        if (s == MEM_ACCESS_SIZE_BYTE) return 1;
        if (s == MEM_ACCESS_SIZE_HALF) return 2;
        return 4;
    endfunction

    // Little-endian byte memory, zero-extended sub-word reads, 256-byte window.
    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nbytes(s); i++) r[8*i +: 8] = mem[8'(a + 32'(i))];
        return r;
    endfunction

    assign mif.busy    = busy;
    assign mif.rd_data = mem_rd(mif.rd_addr, mif.rd_size);

    always @(posedge clk) begin
        if (poke_en)
            for (int i = 0; i < 4; i++) mem[8'(poke_addr + 32'(i))] <= poke_data[8*i +: 8];
        if (mif.wr_enable)
            for (int i = 0; i < nbytes(mif.wr_size); i++)
                mem[8'(mif.wr_addr + 32'(i))] <= mif.wr_data[8*i +: 8];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [1:0] ds, input logic [31:0] dd,
                         input logic b);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw;
        d_addr = da; d_size = ds; d_wdata = dd; busy = b;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h10000, 1'b0, 1'b0, 32'h10000, MEM_ACCESS_SIZE_WORD, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic poke_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [1:0]  d_size;
        logic [31:0] d_wdata;
        logic        busy;
        logic        exp_if_gnt;
        logic        exp_d_gnt;
        logic        exp_wen;
        logic [31:0] exp_rd_addr;
        logic [1:0]  exp_rd_size;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs [10];
    rsp_t        rsp_q [$];
    rsp_t        rsp;
    int          exp_cnt [6];
    logic        exp_dg [6];
    logic [31:0] exp_data;
    int          m_starve;
    logic        e_if, e_d;

    initial begin
        reset = 1'b1;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        drive(1'b1, 32'h10000, 1'b1, 1'b1, 32'h10000, MEM_ACCESS_SIZE_WORD, 32'h1, 1'b0);

        // Reset state: grants forced low even with both requests present.
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_wen", mif.wr_enable, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk32("rst_cnt", 32'(dut.starve_cnt_q), 32'h0);

        for (int a = 0; a < 64; a++) poke_word(32'h10000 + 32'(4 * a), $urandom);

        // Vector table: inputs, then expected grants and read-port drive.
        vecs[0] = '{1'b0, 32'h10020, 1'b0, 1'b0, 32'h10000, MEM_ACCESS_SIZE_WORD, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, 32'h10020, MEM_ACCESS_SIZE_WORD};
        vecs[1] = '{1'b1, 32'h10010, 1'b0, 1'b0, 32'h10000, MEM_ACCESS_SIZE_WORD, 32'h0, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h10010, MEM_ACCESS_SIZE_WORD};
        vecs[2] = '{1'b0, 32'h10040, 1'b1, 1'b1, 32'h10030, MEM_ACCESS_SIZE_HALF, 32'hBEEF, 1'b0,
                    1'b0, 1'b1, 1'b1, 32'h10040, MEM_ACCESS_SIZE_WORD};
        vecs[3] = '{1'b1, 32'h10044, 1'b1, 1'b1, 32'h10048, MEM_ACCESS_SIZE_WORD, 32'hCAFEF00D, 1'b0,
                    1'b1, 1'b1, 1'b1, 32'h10044, MEM_ACCESS_SIZE_WORD};
        vecs[4] = '{1'b0, 32'h10060, 1'b1, 1'b0, 32'h10050, MEM_ACCESS_SIZE_HALF, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, 32'h10050, MEM_ACCESS_SIZE_HALF};
        vecs[5] = '{1'b1, 32'h10064, 1'b1, 1'b0, 32'h10052, MEM_ACCESS_SIZE_BYTE, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, 32'h10052, MEM_ACCESS_SIZE_BYTE};
        vecs[6] = '{1'b1, 32'h10068, 1'b1, 1'b1, 32'h10070, MEM_ACCESS_SIZE_WORD, 32'h55, 1'b1,
                    1'b0, 1'b0, 1'b0, 32'h10068, MEM_ACCESS_SIZE_WORD};
        vecs[7] = '{1'b1, 32'h10068, 1'b0, 1'b0, 32'h10070, MEM_ACCESS_SIZE_WORD, 32'h0, 1'b1,
                    1'b0, 1'b0, 1'b0, 32'h10068, MEM_ACCESS_SIZE_WORD};
        vecs[8] = '{1'b1, 32'h1006C, 1'b0, 1'b0, 32'h10070, MEM_ACCESS_SIZE_WORD, 32'h0, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h1006C, MEM_ACCESS_SIZE_WORD};
        vecs[9] = '{1'b1, 32'h10074, 1'b1, 1'b0, 32'h10078, MEM_ACCESS_SIZE_WORD, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, 32'h10078, MEM_ACCESS_SIZE_WORD};

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
                  vecs[i].d_addr, vecs[i].d_size, vecs[i].d_wdata, vecs[i].busy);
            #1;
            chk1("vec_if_gnt", if_gnt, vecs[i].exp_if_gnt);
            chk1("vec_d_gnt", d_gnt, vecs[i].exp_d_gnt);
            chk1("vec_wen", mif.wr_enable, vecs[i].exp_wen);
            chk32("vec_rd_addr", mif.rd_addr, vecs[i].exp_rd_addr);
            chk32("vec_rd_size", 32'(mif.rd_size), 32'(vecs[i].exp_rd_size));
            exp_data = mem_rd(vecs[i].exp_rd_addr, vecs[i].exp_rd_size);
            @(posedge clk);
            #1;
            chk1("vec_if_rvalid", if_rvalid, vecs[i].exp_if_gnt);
            chk1("vec_d_rvalid", d_rvalid, vecs[i].exp_d_gnt & ~vecs[i].d_we);
            if (vecs[i].exp_if_gnt) chk32("vec_if_rdata", if_rdata, exp_data);
            if (vecs[i].exp_d_gnt && !vecs[i].d_we) chk32("vec_d_rdata", d_rdata, exp_data);
        end

        // Fetch only.
        do_reset();
        poke_word(32'h10000, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b1, 32'h10000, 1'b0, 1'b0, 32'h10100, MEM_ACCESS_SIZE_WORD, '0, 1'b0);
        #1 chk1("fetch_gnt", if_gnt, 1'b1);
        @(posedge clk);
        #1;
        chk1("fetch_rvalid", if_rvalid, 1'b1);
        chk32("fetch_rdata", if_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1 chk1("fetch_rvalid_drop", if_rvalid, 1'b0);

        // Write plus fetch to the same address returns the old word.
        poke_word(32'h10004, 32'hAAAAAAAA);
        @(negedge clk);
        drive(1'b1, 32'h10004, 1'b1, 1'b1, 32'h10004, MEM_ACCESS_SIZE_WORD, 32'h12345678, 1'b0);
        #1;
        chk1("wf_if_gnt", if_gnt, 1'b1);
        chk1("wf_d_gnt", d_gnt, 1'b1);
        chk1("wf_wen", mif.wr_enable, 1'b1);
        @(posedge clk);
        #1;
        chk1("wf_if_rvalid", if_rvalid, 1'b1);
        chk1("wf_d_rvalid", d_rvalid, 1'b0);
        chk32("wf_if_rdata", if_rdata, 32'hAAAAAAAA);
        @(negedge clk);
        drive(1'b0, 32'h10000, 1'b1, 1'b0, 32'h10004, MEM_ACCESS_SIZE_WORD, '0, 1'b0);
        #1 chk1("wf_rd_gnt", d_gnt, 1'b1);
        @(posedge clk);
        #1;
        chk1("wf_rd_rvalid", d_rvalid, 1'b1);
        chk32("wf_rd_rdata", d_rdata, 32'h12345678);

        // Starvation bound: four data grants, one forced fetch, then data again.
        exp_cnt = '{0, 1, 2, 3, 4, 0};
        exp_dg  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h10084, 1'b1, 1'b0, 32'h10080, MEM_ACCESS_SIZE_WORD, '0, 1'b0);
            #1;
            chk32("starve_cnt", 32'(dut.starve_cnt_q), 32'(exp_cnt[k]));
            chk1("starve_d_gnt", d_gnt, exp_dg[k]);
            chk1("starve_if_gnt", if_gnt, ~exp_dg[k]);
            @(posedge clk);
            #1;
            chk1("starve_d_rvalid", d_rvalid, exp_dg[k]);
            chk1("starve_if_rvalid", if_rvalid, ~exp_dg[k]);
        end

        // Sub-word read, zero-extended.
        do_reset();
        poke_word(32'h10000, 32'h11225A33);
        @(negedge clk);
        drive(1'b0, 32'h10000, 1'b1, 1'b0, 32'h10001, MEM_ACCESS_SIZE_BYTE, '0, 1'b0);
        #1 chk1("byte_gnt", d_gnt, 1'b1);
        @(posedge clk);
        #1;
        chk1("byte_rvalid", d_rvalid, 1'b1);
        chk32("byte_rdata", d_rdata, 32'h0000005A);
        chk1("byte_no_if_rvalid", if_rvalid, 1'b0);

        // Busy stalls grants and the write strobe.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h10094, 1'b1, 1'b1, 32'h10090, MEM_ACCESS_SIZE_WORD, 32'h11112222, 1'b1);
            #1;
            chk1("busy_if_gnt", if_gnt, 1'b0);
            chk1("busy_d_gnt", d_gnt, 1'b0);
            chk1("busy_wen", mif.wr_enable, 1'b0);
        end
        @(negedge clk);
        busy = 1'b0;
        #1;
        chk1("unbusy_if_gnt", if_gnt, 1'b1);
        chk1("unbusy_d_gnt", d_gnt, 1'b1);
        chk1("unbusy_wen", mif.wr_enable, 1'b1);
        @(posedge clk);
        #1 chk1("unbusy_if_rvalid", if_rvalid, 1'b1);

        // Reset squashes a pending read response.
        do_reset();
        @(negedge clk);
        drive(1'b0, 32'h10000, 1'b1, 1'b0, 32'h10001, MEM_ACCESS_SIZE_BYTE, '0, 1'b0);
        #1 chk1("sq_gnt", d_gnt, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        #1 chk1("sq_rvalid_mid", d_rvalid, 1'b0);
        @(posedge clk);
        #1;
        chk1("sq_rvalid_after", d_rvalid, 1'b0);
        chk1("sq_if_rvalid", if_rvalid, 1'b0);
        chk32("sq_d_rdata", d_rdata, 32'h0);
        chk32("sq_if_rdata", if_rdata, 32'h0);
        chk32("sq_cnt", 32'(dut.starve_cnt_q), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the reference rules.
        do_reset();
        m_starve = 0;
        rsp_q.delete();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive($urandom_range(3, 0) != 0, 32'h10000 + 32'($urandom_range(255, 0)),
                  $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
                  32'h10000 + 32'($urandom_range(255, 0)), 2'($urandom_range(2, 0)),
                  $urandom, $urandom_range(4, 0) == 0);
            e_if = 1'b0;
            e_d  = 1'b0;
            if (!busy) begin
                if (d_req && d_we) begin
                    e_d = 1'b1; e_if = if_req; m_starve = 0;
                end else if (d_req && if_req && m_starve == LIMIT) begin
                    e_if = 1'b1; m_starve = 0;
                end else if (d_req) begin
                    e_d = 1'b1;
                    m_starve = if_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
                end else if (if_req) begin
                    e_if = 1'b1; m_starve = 0;
                end
            end
            #1;
            chk1("rnd_if_gnt", if_gnt, e_if);
            chk1("rnd_d_gnt", d_gnt, e_d);
            chk1("rnd_wen", mif.wr_enable, e_d & d_we);
            if (e_d && !d_we) begin
                chk32("rnd_rd_addr", mif.rd_addr, d_addr);
                rsp_q.push_back('{1'b1, mem_rd(d_addr, d_size)});
            end else begin
                chk32("rnd_rd_addr", mif.rd_addr, if_addr);
                if (e_if) rsp_q.push_back('{1'b0, mem_rd(if_addr, MEM_ACCESS_SIZE_WORD)});
            end
            @(posedge clk);
            #1;
            chk32("rnd_cnt", 32'(dut.starve_cnt_q), 32'(m_starve));
            if (rsp_q.size() > 0) begin
                rsp = rsp_q.pop_front();
                chk1("rnd_if_rvalid", if_rvalid, ~rsp.is_d);
                chk1("rnd_d_rvalid", d_rvalid, rsp.is_d);
                chk32("rnd_rdata", rsp.is_d ? d_rdata : if_rdata, rsp.data);
            end else begin
                chk1("rnd_if_rvalid", if_rvalid, 1'b0);
                chk1("rnd_d_rvalid", d_rvalid, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
